shift_reg_seq_ctrl: RTL and testbench
=====================================

// Module: shift_reg_seq_ctrl
// PURPOSE
//  Sequencer for the parallel-in register bank. Accepts a WIDTH-bit parallel word over a
//  valid/ready handshake, loads it into an internal D-FF register, then shifts it out one
//  bit per clock with a strobe. Signals completion with a one-cycle done pulse.
//  Sits between a parallel producer and any serial consumer on the same clk domain.
// PARAMETERS
//  WIDTH      4   data word width, >=1
//  MSB_FIRST  1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  p_in       in   WIDTH  parallel data word
//  in_valid   in   1      p_in holds a word to send
//  in_ready   out  1      block can accept a word: (state==IDLE) & ~rst
//  s_out      out  1      serial data bit, meaningful only when s_valid=1
//  s_valid    out  1      s_out carries a data or parity bit this cycle
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle pulse after the last serial bit
// BEHAVIOUR
//  Reset: state=IDLE, data reg=0, bit counter=0, s_out=0, s_valid=0, busy=0, done=0,
//   in_ready=0 while rst is high. All take effect immediately on rst rising, without a clock edge.
//  Accept: word is taken at the rising edge where in_valid & in_ready are both high.
//   p_in is captured into the data register at that edge.
//  FSM: IDLE -> LOAD (1 cycle) -> SHIFT (NBITS cycles) -> DONE (1 cycle) -> IDLE.
//   NBITS = WIDTH, or WIDTH+1 when PARITY_EN is defined.
//  Cycle timing, with k counted in clocks after the accept edge:
//   k=1: LOAD. busy=1, s_valid=0.
//   k=2..NBITS+1: SHIFT. s_valid=1. One bit per cycle, order set by MSB_FIRST.
//   k=NBITS+2: DONE. done=1, s_valid=0, busy=1.
//   k=NBITS+3: IDLE. in_ready=1.
//  All outputs except in_ready are registered. in_ready is decoded from state.
//  Bit counter runs 0..NBITS-1 and leaves SHIFT when it reaches NBITS-1. It never wraps mid-word.
//  While busy: in_valid is ignored, and changes on p_in have no effect on the word being sent.
//  If in_valid is held high, a new word is accepted every NBITS+3 cycles, at each IDLE cycle.
//  Reset during operation: the partial word is discarded, with no done pulse.
//   Operation resumes in IDLE after rst is released.
//  WIDTH=1 is legal: SHIFT lasts a single cycle.
// CONFIGURATION
//  PARITY_EN defined: after the data bits, one extra SHIFT cycle sends even parity
//   (XOR of the captured word) on s_out, with s_valid=1. Done moves one cycle later.
//  PARITY_EN undefined: only WIDTH data bits are sent, and the parity logic is absent.
// TESTING
//  Defaults: WIDTH=4, MSB_FIRST=1, clk period 20.
//  1. Assert rst mid-cycle.
//     -> All outputs are 0 at once. in_ready=0 until release, then 1 in the first cycle after.
//  2. Send 4'b1011.
//     -> s_out = 1,0,1,1 with s_valid=1 at k=2..5. done=1 at k=6. in_ready=1 at k=7.
//  3. Send 4'b1111 then 4'b0111 with in_valid held high.
//     -> Second word accepted at k=7. Stream is 1111 then 0111, separated by the DONE and LOAD gaps.
//  4. Send 4'b1011 and change p_in to 4'b1101 during SHIFT.
//     -> Output stream stays 1,0,1,1.
//  5. Assert rst after the 2nd bit of 4'b1011, then send 4'b1101.
//     -> s_valid drops immediately and no done pulse occurs. Next stream is 1,1,0,1.
//  6. Rebuild with PARITY_EN and send 4'b1011.
//     -> s_out = 1,0,1,1,1 at k=2..6, done at k=7.
//     With MSB_FIRST=0 and PARITY_EN undefined, 4'b1011 -> 1,1,0,1.

Source files
------------

// File: rtl/shift_reg_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shift_reg_seq_ctrl
//  Brief    : Parallel-in / serial-out sequencer. Accepts a WIDTH-bit word on
//             a valid/ready handshake, then streams it out one bit per clock
//             with a strobe and ends with a one-cycle done pulse.
//             Optional feature macro: PARITY_EN (appends an even-parity bit).
//  Revision : 1.0  initial release
// ============================================================================
module shift_reg_seq_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             busy,
  output logic             done
);

`ifdef PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int            CW   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] seq_q, seq_nxt;      // word held in transmit order, bit 0 goes next
  logic [CW-1:0]    cnt, cnt_nxt;        // index of the bit currently on s_out
  logic             s_out_nxt, s_valid_nxt, busy_nxt, done_nxt;
  logic [WIDTH-1:0] ordered;             // p_in rearranged so index 0 is sent first
  logic [NBITS-1:0] load_word;

  // Reorder the incoming word once so the shifter always sends bit 0 first.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_order
      if (MSB_FIRST) begin : g_msb
        assign ordered[i] = p_in[WIDTH-1-i];
      end else begin : g_lsb
        assign ordered[i] = p_in[i];
      end
    end
  endgenerate

`ifdef PARITY_EN
  // Even parity of the captured word rides behind the data bits.
  assign load_word = {^p_in, ordered};
`else
  assign load_word = ordered;
`endif

  // Ready only in IDLE and never while reset is asserted.
  assign in_ready = (state == IDLE) & ~rst;

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_nxt   = state;
    seq_nxt     = seq_q;
    cnt_nxt     = cnt;
    s_out_nxt   = 1'b0;
    s_valid_nxt = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_nxt = LOAD;
          seq_nxt   = load_word;
          busy_nxt  = 1'b1;
        end
      end
      LOAD: begin
        state_nxt   = SHIFT;
        cnt_nxt     = '0;
        s_out_nxt   = seq_q[0];
        seq_nxt     = seq_q >> 1;
        s_valid_nxt = 1'b1;
        busy_nxt    = 1'b1;
      end
      SHIFT: begin
        busy_nxt = 1'b1;
        if (cnt == LAST) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt     = cnt + CW'(1);
          s_out_nxt   = seq_q[0];
          seq_nxt     = seq_q >> 1;
          s_valid_nxt = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, shifter, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      seq_q   <= '0;
      cnt     <= '0;
      s_out   <= 1'b0;
      s_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      seq_q   <= seq_nxt;
      cnt     <= cnt_nxt;
      s_out   <= s_out_nxt;
      s_valid <= s_valid_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_reg_seq_ctrl
//  Brief    : Directed bench for shift_reg_seq_ctrl. Two instances share the
//             inputs: one sends MSB first, the other LSB first.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_reg_seq_ctrl;

`ifdef PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] p_in;
  logic       in_ready, s_out, s_valid, busy, done;
  logic       in_ready_l, s_out_l, s_valid_l, busy_l, done_l;

  int n_cmp = 0;
  int n_err = 0;

  shift_reg_seq_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .p_in(p_in), .in_valid(in_valid),
    .in_ready(in_ready), .s_out(s_out), .s_valid(s_valid), .busy(busy), .done(done)
  );

  shift_reg_seq_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .p_in(p_in), .in_valid(in_valid),
    .in_ready(in_ready_l), .s_out(s_out_l), .s_valid(s_valid_l), .busy(busy_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Send one word starting from an IDLE negedge. exp_m / exp_l hold the
  // expected stream with the first bit at index NB-1.
  task automatic run_word(input logic [3:0] w, input logic [4:0] exp_m, input logic [4:0] exp_l,
                          input bit keep, input bit mid_en, input logic [3:0] mid);
    p_in     = w;
    in_valid = 1'b1;
    @(negedge clk);
    check("load_busy",   busy,     1'b1);
    check("load_svalid", s_valid,  1'b0);
    check("load_ready",  in_ready, 1'b0);
    check("load_done",   done,     1'b0);
    if (!keep) in_valid = 1'b0;
    for (int j = 0; j < NB; j++) begin
      @(negedge clk);
      check("sh_valid",     s_valid,   1'b1);
      check("sh_valid_lsb", s_valid_l, 1'b1);
      check("sh_bit_msb",   s_out,     exp_m[NB-1-j]);
      check("sh_bit_lsb",   s_out_l,   exp_l[NB-1-j]);
      check("sh_done",      done,      1'b0);
      check("sh_busy",      busy,      1'b1);
      if (mid_en && j == 0) p_in = mid;
    end
    @(negedge clk);
    check("dn_done",     done,    1'b1);
    check("dn_done_lsb", done_l,  1'b1);
    check("dn_svalid",   s_valid, 1'b0);
    check("dn_busy",     busy,    1'b1);
    check("dn_ready",    in_ready, 1'b0);
    @(negedge clk);
    check("idle_ready", in_ready, 1'b1);
    check("idle_busy",  busy,     1'b0);
    check("idle_done",  done,     1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    p_in     = 4'b0000;
    repeat (2) @(negedge clk);
    check("rst_ready",  in_ready, 1'b0);
    check("rst_busy",   busy,     1'b0);
    check("rst_svalid", s_valid,  1'b0);
    check("rst_sout",   s_out,    1'b0);
    check("rst_done",   done,     1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", in_ready, 1'b1);
    check("rel_busy",  busy,     1'b0);

    // Basic word.
`ifdef PARITY_EN
    run_word(4'b1011, 5'b10111, 5'b11011, 1'b0, 1'b0, 4'b0000);
`else
    run_word(4'b1011, 5'b01011, 5'b01101, 1'b0, 1'b0, 4'b0000);
`endif

    // Back-to-back with in_valid held high the whole time.
`ifdef PARITY_EN
    run_word(4'b1111, 5'b11110, 5'b11110, 1'b1, 1'b0, 4'b0000);
    run_word(4'b0111, 5'b01111, 5'b11101, 1'b0, 1'b0, 4'b0000);
`else
    run_word(4'b1111, 5'b01111, 5'b01111, 1'b1, 1'b0, 4'b0000);
    run_word(4'b0111, 5'b00111, 5'b01110, 1'b0, 1'b0, 4'b0000);
`endif

    // p_in changes during SHIFT must not disturb the stream.
`ifdef PARITY_EN
    run_word(4'b1011, 5'b10111, 5'b11011, 1'b0, 1'b1, 4'b1101);
`else
    run_word(4'b1011, 5'b01011, 5'b01101, 1'b0, 1'b1, 4'b1101);
`endif

    // Reset asserted mid-cycle after the second bit.
    p_in     = 4'b1011;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pr_bit0",     s_out,   1'b1);
    check("pr_bit0_lsb", s_out_l, 1'b1);
    @(negedge clk);
    check("pr_bit1",     s_out,   1'b0);
    check("pr_bit1_lsb", s_out_l, 1'b1);
    check("pr_valid",    s_valid, 1'b1);
    #5 rst = 1'b1;
    #1;
    check("ar_svalid",     s_valid,   1'b0);
    check("ar_svalid_lsb", s_valid_l, 1'b0);
    check("ar_sout",       s_out,     1'b0);
    check("ar_busy",       busy,      1'b0);
    check("ar_done",       done,      1'b0);
    check("ar_ready",      in_ready,  1'b0);
    @(negedge clk);
    check("ar_hold_ready", in_ready, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_done",   done,     1'b0);
      check("post_svalid", s_valid,  1'b0);
      check("post_ready",  in_ready, 1'b1);
    end
`ifdef PARITY_EN
    run_word(4'b1101, 5'b11011, 5'b10111, 1'b0, 1'b0, 4'b0000);
`else
    run_word(4'b1101, 5'b01101, 5'b01011, 1'b0, 1'b0, 4'b0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
